// File: rtl/ntt_butterfly_addsub.sv
// NTT Cooley-Tukey butterfly back end: aligns a with the Barrett reducer output t,
// forms (a+t) mod q and (a-t) mod q, buffers them in a credit-controlled FWFT FIFO.
module ntt_butterfly_addsub #(
    parameter  int unsigned data_size    = 32,
    parameter  int unsigned prime_number = 2971,
    parameter  int unsigned RED_LATENCY  = 2,
    parameter  int unsigned N            = 256,
    parameter  int unsigned DEPTH        = RED_LATENCY + 2,
    localparam int unsigned CW           = data_size / 2,
    localparam int unsigned IDX_W        = (N > 4) ? $clog2(N / 2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CW-1:0]    in_a,
    output logic             in_ready,
    input  logic [CW-1:0]    t_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_hi,
    output logic [CW-1:0]    out_lo,
    output logic [IDX_W-1:0] bfly_idx,
    output logic             stage_done
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned LW   = $clog2(RED_LATENCY + 1);

    localparam logic [CW:0]      Q        = (CW + 1)'(prime_number);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N / 2 - 1);
    localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);

    typedef struct packed {
        logic [CW-1:0] hi;
        logic [CW-1:0] lo;
    } pair_t;

    logic [CW-1:0]          dl_a_q [RED_LATENCY];
    logic [CW-1:0]          dl_a_d [RED_LATENCY];
    logic [RED_LATENCY-1:0] dl_v_q;
    logic [RED_LATENCY-1:0] dl_v_d;

    pair_t                  mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   done_q, done_d;

    logic [LW-1:0]          inflight;
    logic                   accept;
    logic                   wr_en;
    logic                   pop;
    logic [CW-1:0]          a_tail;
    logic [CW:0]            sum;
    logic [CW:0]            diff;
    pair_t                  result;
    pair_t                  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits: everything already promised (buffered or in the reducer) plus this issue.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RED_LATENCY; i++) begin
            inflight = inflight + LW'(dl_v_q[i]);
        end
    end

    assign in_ready = !rst && ((32'(cnt_q) + 32'(inflight) + 32'd1) <= DEPTH);
    assign accept   = in_valid && in_ready;

    // Alignment line mirrors the reducer pipeline, so it advances unconditionally.
    always_comb begin
        dl_a_d    = dl_a_q;
        dl_v_d    = dl_v_q;
        dl_a_d[0] = in_a;
        dl_v_d[0] = accept;
        for (int unsigned i = 1; i < RED_LATENCY; i++) begin
            dl_a_d[i] = dl_a_q[i-1];
            dl_v_d[i] = dl_v_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v_q <= '0;
            for (int unsigned i = 0; i < RED_LATENCY; i++) begin
                dl_a_q[i] <= '0;
            end
        end else begin
            dl_v_q <= dl_v_d;
            dl_a_q <= dl_a_d;
        end
    end

    // Modular add/sub; operands are below q so one conditional correction suffices.
    assign a_tail = dl_a_q[RED_LATENCY-1];
    assign wr_en  = dl_v_q[RED_LATENCY-1];

    always_comb begin
        sum  = {1'b0, a_tail} + {1'b0, t_in};
        diff = {1'b0, a_tail} - {1'b0, t_in};
        result.hi = (sum >= Q) ? CW'(sum - Q) : CW'(sum);
        result.lo = (a_tail >= t_in) ? CW'(diff) : CW'(diff + Q);
    end

    // First-word-fall-through output buffer.
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_hi    = out_valid ? head.hi : '0;
    assign out_lo    = out_valid ? head.lo : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Per-stage butterfly index; the done pulse follows the last handshake of a stage.
    always_comb begin
        idx_d  = idx_q;
        done_d = 1'b0;
        if (pop) begin
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            done_d = (idx_q == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign bfly_idx   = idx_q;
    assign stage_done = done_q;

endmodule

// File: tb/tb_ntt_butterfly_addsub.sv
// Scoreboard bench for ntt_butterfly_addsub: the driver pushes expected pairs on
// issue, a negedge monitor pops and compares on every output handshake.
module tb_ntt_butterfly_addsub;

    localparam int Q     = 2971;
    localparam int L     = 2;
    localparam int DEPTH = 4;
    localparam int NB    = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic        in_ready;
    logic [15:0] t_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_hi;
    logic [15:0] out_lo;
    logic [6:0]  bfly_idx;
    logic        stage_done;

    ntt_butterfly_addsub dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_ready   (in_ready),
        .t_in       (t_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hi     (out_hi),
        .out_lo     (out_lo),
        .bfly_idx   (bfly_idx),
        .stage_done (stage_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] tp [L];
    logic [15:0] t_cur = '0;
    exp_t        exp_cur = '0;
    int          n_hs = 0;
    int          done_pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int t);
        exp_t r;
        r.hi = 16'((a + t) % Q);
        r.lo = 16'((a - t + Q) % Q);
        return r;
    endfunction

    task automatic issue(input int a, input int t, input int hi, input int lo);
        in_valid = 1'b1;
        in_a     = 16'(a);
        t_cur    = 16'(t);
        exp_cur.hi = 16'(hi);
        exp_cur.lo = 16'(lo);
    endtask

    task automatic issue_rand();
        int a;
        int t;
        exp_t e;
        a = int'($urandom_range(0, Q - 1));
        t = int'($urandom_range(0, Q - 1));
        e = model(a, t);
        issue(a, t, int'(e.hi), int'(e.lo));
    endtask

    // One clock: record acceptance, advance the bench's reducer model, drive t_in.
    task automatic step();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        for (int i = L - 1; i > 0; i--) tp[i] = tp[i-1];
        tp[0] = acc ? t_cur : 16'h5a5a;
        t_in  = tp[L-1];
        if (acc) exp_q.push_back(exp_cur);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 200) begin
            step();
            cyc++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pops, index/stage_done tracking, stall stability, overflow bound.
    int   exp_idx = 0;
    logic wrap_pend = 1'b0;
    logic held = 1'b0;
    logic [15:0] held_hi = '0;
    logic [15:0] held_lo = '0;

    always @(negedge clk) begin
        exp_t e;
        logic next_wrap;
        if (rst) begin
            exp_idx   = 0;
            wrap_pend = 1'b0;
            held      = 1'b0;
        end else begin
            if (exp_q.size() > DEPTH) begin
                check("outstanding_bound", exp_q.size(), DEPTH);
            end
            if (stage_done || wrap_pend) begin
                check("stage_done", int'(stage_done), int'(wrap_pend));
                if (stage_done) done_pulses++;
            end
            if (held && out_valid) begin
                check("stall_hi_stable", int'(out_hi), int'(held_hi));
                check("stall_lo_stable", int'(out_lo), int'(held_lo));
            end
            next_wrap = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got hi=%0d lo=%0d, expected no output", out_hi, out_lo);
                end else begin
                    e = exp_q.pop_front();
                    check("out_hi", int'(out_hi), int'(e.hi));
                    check("out_lo", int'(out_lo), int'(e.lo));
                    check("bfly_idx", int'(bfly_idx), exp_idx);
                end
                n_hs++;
                next_wrap = (exp_idx == NB - 1);
                exp_idx   = (exp_idx + 1) % NB;
            end
            wrap_pend = next_wrap;
            held      = out_valid && !out_ready;
            held_hi   = out_hi;
            held_lo   = out_lo;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int p0;
        int issued;
        int cyc;
        int drops;
        int hs;
        int bp_a  [4] = '{1, 2970, 1500, 10};
        int bp_t  [4] = '{1, 1, 1500, 20};
        int bp_hi [4] = '{2, 0, 29, 30};
        int bp_lo [4] = '{0, 2969, 0, 2961};

        for (int i = 0; i < L; i++) tp[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_hi", int'(out_hi), 0);
        check("rst_out_lo", int'(out_lo), 0);
        check("rst_bfly_idx", int'(bfly_idx), 0);
        check("rst_stage_done", int'(stage_done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);
        out_ready = 1'b1;

        // Reference vector and latency
        issue(1000, 2405, 434, 1566);
        step();
        in_valid = 1'b0;
        check("latency_k1", int'(out_valid), 0);
        step();
        check("latency_k2", int'(out_valid), 0);
        step();
        check("latency_k3", int'(out_valid), 1);
        drain();

        // Wrap cases back to back
        issue(100, 2900, 29, 171);  step();
        issue(2970, 2970, 2969, 0); step();
        issue(5, 7, 12, 2969);      step();
        issue(0, 0, 0, 0);          step();
        drain();

        // Backpressure: credits allow exactly DEPTH acceptances
        out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            issue(bp_a[nacc % 4], bp_t[nacc % 4], bp_hi[nacc % 4], bp_lo[nacc % 4]);
            if (in_ready) nacc++;
            step();
        end
        check("bp_accepted", nacc, 4);
        check("bp_in_ready_low", int'(in_ready), 0);
        drain();
        check("bp_in_ready_back", int'(in_ready), 1);

        // Reset mid-stream with three buffered results
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_rand();
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("pre_rst_buffered", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_hi", int'(out_hi), 0);
        check("mid_rst_out_lo", int'(out_lo), 0);
        check("mid_rst_bfly_idx", int'(bfly_idx), 0);
        check("mid_rst_stage_done", int'(stage_done), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        for (int i = 0; i < L; i++) tp[i] = '0;
        t_in = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (10) step();

        // Stage counter over one full stage with random backpressure
        p0 = done_pulses;
        issued = 0;
        cyc = 0;
        while (issued < NB && cyc < 3000) begin
            issue_rand();
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready) issued++;
            step();
            cyc++;
        end
        check("stage_issued", issued, NB);
        drain();
        step();
        step();
        check("stage_done_pulses", done_pulses - p0, 1);
        check("stage_idx_wrapped", int'(bfly_idx), 0);

        // Full throughput
        out_ready = 1'b1;
        drops = 0;
        hs = 0;
        for (int i = 0; i < 300; i++) begin
            issue_rand();
            if (!in_ready) drops++;
            if (out_valid) hs++;
            step();
        end
        check("tp_in_ready_drops", drops, 0);
        check("tp_outputs_in_window", hs, 297);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
